// File: rtl/exc_redirect_ctrl.sv
// Exception take/return controller: queues the oldest exception request and, when its instruction reaches the ROB head, flushes and redirects fetch.
// Latency: flush starts the cycle after the ROB head match and lasts FLUSH_CYCLES cycles; the redirect strobe follows. An eret redirects one cycle after it is sampled.
// Backpressure: none. Requests that arrive while flushing, redirecting or in the handler are dropped, and unknown handler addresses are ignored.
module exc_redirect_ctrl #(
    parameter int INUM_W       = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       exc_handler_addr,
    input  logic [INUM_W-1:0] exc_inst_num,
    input  logic              rob_head_valid,
    input  logic [INUM_W-1:0] rob_head_inst_num,
    input  logic [15:0]       rob_head_pc,
    input  logic              eret,
    output logic              flush,
    output logic              redirect_valid,
    output logic [15:0]       redirect_addr,
    output logic [15:0]       epc,
    output logic [2:0]        cause,
    output logic              in_handler
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_FLUSH,
        S_REDIR,
        S_HAND,
        S_RET
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       pend_addr_q, pend_addr_d;
    logic [INUM_W-1:0] pend_tag_q, pend_tag_d;
    logic [2:0]        pend_cause_q, pend_cause_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [15:0]       epc_q, epc_d;
    logic [2:0]        cause_q, cause_d;
    logic              in_handler_q, in_handler_d;
    logic [15:0]       raddr_q, raddr_d;

    logic [2:0]        req_cause;
    logic              req_vld;
    logic [INUM_W-1:0] age_new;
    logic [INUM_W-1:0] age_pend;
    logic [15:0]       eff_addr;
    logic [INUM_W-1:0] eff_tag;
    logic [2:0]        eff_cause;

    // Decode the handler address into a cause code; unknown addresses do not count as requests.
    always_comb begin
        req_cause = 3'd0;
        case (exc_handler_addr)
            16'h02BC: req_cause = 3'd1;
            16'h02E4: req_cause = 3'd2;
            16'h030C: req_cause = 3'd3;
            16'h0334: req_cause = 3'd4;
            default:  req_cause = 3'd0;
        endcase
        req_vld  = (req_cause != 3'd0);
        // Distance from the ROB head; the subtraction wraps so tags stay comparable across rollover.
        age_new  = exc_inst_num - rob_head_inst_num;
        age_pend = pend_tag_q - rob_head_inst_num;
    end

    // Pending request after any same-cycle replacement by an older request.
    always_comb begin
        eff_addr  = pend_addr_q;
        eff_tag   = pend_tag_q;
        eff_cause = pend_cause_q;
        if (req_vld && (age_new < age_pend)) begin
            eff_addr  = exc_handler_addr;
            eff_tag   = exc_inst_num;
            eff_cause = req_cause;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_addr_q  <= 16'h0000;
            pend_tag_q   <= '0;
            pend_cause_q <= 3'd0;
            cnt_q        <= 3'd0;
            epc_q        <= 16'h0000;
            cause_q      <= 3'd0;
            in_handler_q <= 1'b0;
            raddr_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_tag_q   <= pend_tag_d;
            pend_cause_q <= pend_cause_d;
            cnt_q        <= cnt_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            in_handler_q <= in_handler_d;
            raddr_q      <= raddr_d;
        end
    end

    // Next state, plus the registers that load on particular transitions.
    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_tag_d   = pend_tag_q;
        pend_cause_d = pend_cause_q;
        cnt_d        = cnt_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        in_handler_d = in_handler_q;
        raddr_d      = raddr_q;
        case (state_q)
            S_IDLE: begin
                // Capture only. A head match in the same cycle is picked up from PENDING next cycle.
                if (req_vld) begin
                    pend_addr_d  = exc_handler_addr;
                    pend_tag_d   = exc_inst_num;
                    pend_cause_d = req_cause;
                    state_d      = S_PEND;
                end
            end
            S_PEND: begin
                pend_addr_d  = eff_addr;
                pend_tag_d   = eff_tag;
                pend_cause_d = eff_cause;
                if (rob_head_valid && (rob_head_inst_num == eff_tag)) begin
                    epc_d   = rob_head_pc;
                    cause_d = eff_cause;
                    cnt_d   = FLUSH_INIT;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q <= 3'd1) begin
                    raddr_d = pend_addr_q;
                    state_d = S_REDIR;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_REDIR: begin
                in_handler_d = 1'b1;
                state_d      = S_HAND;
            end
            S_HAND: begin
                if (eret) begin
                    raddr_d = epc_q;
                    state_d = S_RET;
                end
            end
            S_RET: begin
                in_handler_d = 1'b0;
                cause_d      = 3'd0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on state and registers, so an asynchronous reset clears them at once.
    always_comb begin
        flush          = (state_q == S_FLUSH) || (state_q == S_RET);
        redirect_valid = (state_q == S_REDIR) || (state_q == S_RET);
        redirect_addr  = raddr_q;
        epc            = epc_q;
        cause          = cause_q;
        in_handler     = in_handler_q;
    end

endmodule

// File: doc/exc_redirect_ctrl.md
Name: exc_redirect_ctrl

Overview:
- Consumer end of the exception vector interface: takes the registered handler address and instruction number from the vector table and decides when the exception is taken.
- Holds the request until the faulting instruction reaches the ROB head, then flushes the pipeline, saves EPC and cause, and redirects fetch to the handler.
- Handles return-from-exception (eret) by redirecting fetch back to the saved EPC.
- Sits between the vector table, the ROB head/commit logic and the fetch PC mux.

Parameters:
- INUM_W, 6, instruction-number (ROB tag) width.
- FLUSH_CYCLES, 2, cycles `flush` is held high; valid range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- exc_handler_addr  in  16  handler address from the vector table; 16'h0000 = no request.
- exc_inst_num  in  INUM_W  tag of the faulting instruction.
- rob_head_valid  in  1  ROB head entry is valid.
- rob_head_inst_num  in  INUM_W  tag at the ROB head.
- rob_head_pc  in  16  PC of the ROB head instruction.
- eret  in  1  eret is committing this cycle (one-cycle pulse).
- flush  out  1  pipeline flush, all stages.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_addr  out  16  fetch redirect target.
- epc  out  16  saved PC of the faulting instruction.
- cause  out  3  1=illegal, 2=LS, 3=div0, 4=address, 0=none.
- in_handler  out  1  handler is executing; new requests are masked.

Behaviour:
- Reset (async, rst=1): state=IDLE; flush=0, redirect_valid=0, redirect_addr=0, epc=0, cause=0, in_handler=0; pending registers cleared.
- Request decode: request = (exc_handler_addr != 0).
  - Cause mapping: 02BC->1, 02E4->2, 030C->3, 0334->4.
  - Any other nonzero address is ignored and never captured.
- Age compare: age(x) = (x - rob_head_inst_num) mod 2^INUM_W; smaller age = older. This makes the compare wrap-safe.
- IDLE:
  - Request -> capture addr, inst_num and cause into pending; next state PENDING.
  - eret is ignored in IDLE.
- PENDING:
  - A new request whose age < pending age replaces the pending request. A younger or equal-age request is dropped.
  - When rob_head_valid and rob_head_inst_num == pending inst_num (using the post-replacement value, same cycle allowed):
    - epc <= rob_head_pc, cause <= pending cause.
    - Next state FLUSH with counter = FLUSH_CYCLES.
  - Until that match, no outputs change.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles; requests are ignored.
  - On the last flush cycle, next state REDIRECT.
- REDIRECT:
  - redirect_valid=1 and redirect_addr=pending addr for exactly one cycle; flush=0.
  - in_handler goes to 1 on the following edge. Next state HANDLER.
- HANDLER:
  - in_handler=1; all requests are ignored (no nesting).
  - eret -> next state RET.
- RET:
  - One cycle: flush=1, redirect_valid=1, redirect_addr=epc.
  - Next edge: in_handler=0, cause=0, state=IDLE. epc keeps its value.
- Latency:
  - ROB-head match at edge N -> flush high from N+1 for FLUSH_CYCLES cycles.
  - redirect_valid at cycle N+1+FLUSH_CYCLES.
  - eret at edge M -> RET redirect in the cycle after M.
- Simultaneous events:
  - In IDLE, a request whose tag already equals the ROB head is captured only; the match is checked in PENDING on the next cycle.
  - rst asserted mid-FLUSH, REDIRECT or HANDLER forces IDLE immediately; outputs drop without waiting for a clock edge.
- redirect_addr holds its last value when redirect_valid=0.

Test Plan:
- Basic take: addr 030C, tag 5; ROB head reaches tag 5 with pc 0x0120 three cycles later -> flush high 2 cycles, then redirect 030C one cycle, epc=0x0120, cause=3, in_handler=1.
- Older replaces younger: pending tag 7 (head=4), then addr 02BC tag 5 -> taken with redirect 02BC, cause=1, when head=5; tag 7 never taken.
- Wrap-around age: head=62, pending tag 1, new request tag 63 -> tag 63 replaces it (age 1 < age 3).
- Masking: in HANDLER, addr 0334 tag 2 -> no flush and no redirect; eret -> one cycle of flush=1 with redirect to saved epc; in_handler=0 next cycle.
- Invalid/none: addr 0x0000 or 0x0100 -> state stays IDLE, all outputs 0.
- Reset mid-FLUSH: rst pulse on the first flush cycle -> flush=0 immediately, no redirect ever issued, cause=0.
